// File: rtl/dct8_pkg.sv
// Shared lane indices and range helpers for the stage-5 DCT butterfly.
package dct8_pkg;

  // Lane positions inside one 8-lane vector.
  localparam int L0 = 0;
  localparam int L1 = 1;
  localparam int L2 = 2;
  localparam int L3 = 3;
  localparam int L4 = 4;
  localparam int L5 = 5;
  localparam int L6 = 6;
  localparam int L7 = 7;

  // Widest internal value: 64-bit lanes plus two guard bits.
  localparam int MAX_XW = 66;

  // Flat lane number of lane k in channel c.
  function automatic int lane(input int c, input int k);
    return c * 8 + k;
  endfunction

  // Largest value representable in a signed data_w-bit lane.
  function automatic logic signed [MAX_XW-1:0] max_w(input int data_w);
    logic signed [MAX_XW-1:0] one;
    one = 1;
    return (one <<< (data_w - 1)) - one;
  endfunction

  // True when value lies outside the signed data_w-bit range.
  function automatic logic ovf_w(input logic signed [MAX_XW-1:0] value, input int data_w);
    logic signed [MAX_XW-1:0] hi;
    logic signed [MAX_XW-1:0] lo;
    hi = max_w(data_w);
    lo = -hi - 1;
    return (value > hi) || (value < lo);
  endfunction

  // Clamp value to the signed data_w-bit range.
  function automatic logic signed [MAX_XW-1:0] sat_w(input logic signed [MAX_XW-1:0] value,
                                                      input int data_w);
    logic signed [MAX_XW-1:0] hi;
    logic signed [MAX_XW-1:0] lo;
    hi = max_w(data_w);
    lo = -hi - 1;
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

endpackage

// File: rtl/dct8_pipe_reg.sv
// One valid/ready register slice with bubble collapse and no skid buffer.
module dct8_pipe_reg
  import dct8_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] src_data,
  input  logic         src_valid,
  output logic         src_ready,
  output logic [W-1:0] dst_data,
  output logic         dst_valid,
  input  logic         dst_ready
);

  // The slice can take a beat when empty or when its current beat leaves now.
  assign src_ready = !dst_valid || dst_ready;

  // Valid bit follows the upstream valid whenever the slot is free to change.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with <= so every register samples pre-edge values.
    if (rst) dst_valid <= 1'b0;
    else if (src_ready) dst_valid <= src_valid;
  end

  // Payload loads only on a real transfer, so idle input data never enters.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the payload is reset too, because the output data must read 0 after reset.
    if (rst) dst_data <= '0;
    else if (src_valid && src_ready) dst_data <= src_data;
  end

endmodule

// File: rtl/dct8_stage5_pipe.sv
// Stage-5 butterfly of the 8-point DCT: NCH vectors per beat, 1 or 2 pipe
// stages, wrap or saturate, per-channel overflow flag, valid/ready on both sides.
module dct8_stage5_pipe
  import dct8_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NCH    = 1,
  parameter int PIPE   = 2,
  parameter int SAT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*8*DATA_W-1:0] i_data_in,
  input  logic                  i_valid,
  output logic                  i_ready,
  output logic [NCH*8*DATA_W-1:0] o_data_out,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [NCH-1:0]        o_ovf
);

  // Internal width: two guard bits keep every y exact.
  localparam int XW = DATA_W + 2;
  // Per-channel mid-point record: 8 values of XW bits plus a partial overflow bit.
  localparam int CW = 8 * XW + 1;
  localparam int MW = NCH * CW;
  localparam int DW = NCH * 8 * DATA_W;
  localparam int OW = DW + NCH;

  logic [MW-1:0] mid_comb;
  logic [MW-1:0] mid;
  logic [OW-1:0] out_comb;
  logic [OW-1:0] out_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    // First half: y0, y4, y2, y6 are final; d and s are the shared partial sums.
    logic signed [XW-1:0] x [8];
    logic signed [XW-1:0] a [8];
    for (genvar k = 0; k < 8; k++) begin : g_in
      assign x[k] = XW'(signed'(i_data_in[lane(c, k)*DATA_W +: DATA_W]));
      assign mid_comb[c*CW + k*XW +: XW] = a[k];
    end
    assign a[0] = x[L0] + x[L1];
    assign a[1] = x[L0] - x[L1];
    assign a[2] = x[L3] + x[L2];
    assign a[3] = x[L3] - x[L2];
    assign a[4] = x[L7] - x[L5];
    assign a[5] = x[L7] + x[L5];
    assign a[6] = x[L4];
    assign a[7] = x[L6];
    assign mid_comb[c*CW + CW-1] = ovf_w(a[0], DATA_W) | ovf_w(a[1], DATA_W) |
                                   ovf_w(a[2], DATA_W) | ovf_w(a[3], DATA_W);

    // Second half: finish y5, y3, y1, y7 and reduce every lane to DATA_W bits.
    logic signed [XW-1:0] m [8];
    logic signed [XW-1:0] y [8];
    for (genvar k = 0; k < 8; k++) begin : g_mid
      assign m[k] = mid[c*CW + k*XW +: XW];
    end
    assign y[L0] = m[0];
    assign y[L4] = m[1];
    assign y[L2] = m[2];
    assign y[L6] = m[3];
    assign y[L5] = m[4] + m[6];
    assign y[L3] = m[4] - m[6];
    assign y[L1] = m[5] + m[7];
    assign y[L7] = m[5] - m[7];
    for (genvar k = 0; k < 8; k++) begin : g_out
      assign out_comb[lane(c, k)*DATA_W +: DATA_W] =
        (SAT != 0) ? DATA_W'(sat_w(y[k], DATA_W)) : DATA_W'(y[k]);
    end
    assign out_comb[DW + c] = mid[c*CW + CW-1] |
                              ovf_w(y[L5], DATA_W) | ovf_w(y[L3], DATA_W) |
                              ovf_w(y[L1], DATA_W) | ovf_w(y[L7], DATA_W);
  end

  if (PIPE == 2) begin : g_two
    // Split adder tree: mid-point register feeds the output register.
    logic mid_valid;
    logic mid_ready;

    dct8_pipe_reg #(.W(MW)) u_reg0 (
      .clk       (clk),
      .rst       (rst),
      .src_data  (mid_comb),
      .src_valid (i_valid),
      .src_ready (i_ready),
      .dst_data  (mid),
      .dst_valid (mid_valid),
      .dst_ready (mid_ready)
    );

    dct8_pipe_reg #(.W(OW)) u_reg1 (
      .clk       (clk),
      .rst       (rst),
      .src_data  (out_comb),
      .src_valid (mid_valid),
      .src_ready (mid_ready),
      .dst_data  (out_q),
      .dst_valid (o_valid),
      .dst_ready (o_ready)
    );
  end else begin : g_one
    // Single stage: the whole butterfly settles into the output register.
    assign mid = mid_comb;

    dct8_pipe_reg #(.W(OW)) u_reg1 (
      .clk       (clk),
      .rst       (rst),
      .src_data  (out_comb),
      .src_valid (i_valid),
      .src_ready (i_ready),
      .dst_data  (out_q),
      .dst_valid (o_valid),
      .dst_ready (o_ready)
    );
  end

  assign o_data_out = out_q[DW-1:0];
  assign o_ovf      = out_q[OW-1:DW];

endmodule

// File: tb/tb_dct8_stage5_pipe.sv
// Directed and scoreboarded checks of dct8_stage5_pipe in several configurations.
module tb_dct8_stage5_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 64-bit, one channel, two stages, wrap.
  logic [511:0] a_data_in = '0;
  logic         a_valid = 1'b0;
  logic         a_ready;
  logic [511:0] a_data_out;
  logic         a_out_valid;
  logic         a_out_ready = 1'b1;
  logic [0:0]   a_ovf;

  // 8-bit, four channels, shared input stream.
  logic [255:0] d8 = '0;
  logic         v8 = 1'b0;
  logic         r8_out = 1'b1;
  logic         w8_ready, p1_ready, s8_ready;
  logic [255:0] w8_data, p1_data, s8_data;
  logic         w8_valid, p1_valid, s8_valid;
  logic [3:0]   w8_ovf, p1_ovf, s8_ovf;

  dct8_stage5_pipe #(.DATA_W(64), .NCH(1), .PIPE(2), .SAT(0)) u_a (
    .clk(clk), .rst(rst), .i_data_in(a_data_in), .i_valid(a_valid), .i_ready(a_ready),
    .o_data_out(a_data_out), .o_valid(a_out_valid), .o_ready(a_out_ready), .o_ovf(a_ovf));

  dct8_stage5_pipe #(.DATA_W(8), .NCH(4), .PIPE(2), .SAT(0)) u_w8 (
    .clk(clk), .rst(rst), .i_data_in(d8), .i_valid(v8), .i_ready(w8_ready),
    .o_data_out(w8_data), .o_valid(w8_valid), .o_ready(r8_out), .o_ovf(w8_ovf));

  dct8_stage5_pipe #(.DATA_W(8), .NCH(4), .PIPE(1), .SAT(0)) u_p1 (
    .clk(clk), .rst(rst), .i_data_in(d8), .i_valid(v8), .i_ready(p1_ready),
    .o_data_out(p1_data), .o_valid(p1_valid), .o_ready(r8_out), .o_ovf(p1_ovf));

  dct8_stage5_pipe #(.DATA_W(8), .NCH(4), .PIPE(1), .SAT(1)) u_s8 (
    .clk(clk), .rst(rst), .i_data_in(d8), .i_valid(v8), .i_ready(s8_ready),
    .o_data_out(s8_data), .o_valid(s8_valid), .o_ready(r8_out), .o_ovf(s8_ovf));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference butterfly for four 8-bit channels, computed exactly in int.
  function automatic void model8(input logic [255:0] xv, input bit sat,
                                 output logic [255:0] yv, output logic [3:0] ov);
    int x[8];
    int y[8];
    yv = '0;
    ov = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 8; k++) x[k] = int'($signed(xv[(c*8+k)*8 +: 8]));
      y[0] = x[0] + x[1];
      y[4] = x[0] - x[1];
      y[2] = x[3] + x[2];
      y[6] = x[3] - x[2];
      y[5] = (x[7] - x[5]) + x[4];
      y[3] = (x[7] - x[5]) - x[4];
      y[1] = (x[7] + x[5]) + x[6];
      y[7] = (x[7] + x[5]) - x[6];
      for (int k = 0; k < 8; k++) begin
        if (y[k] > 127 || y[k] < -128) ov[c] = 1'b1;
        if (sat && y[k] > 127)       yv[(c*8+k)*8 +: 8] = 8'h7F;
        else if (sat && y[k] < -128) yv[(c*8+k)*8 +: 8] = 8'h80;
        else                         yv[(c*8+k)*8 +: 8] = 8'(y[k]);
      end
    end
  endfunction

  // Reference butterfly for one 64-bit channel, wrap mode.
  function automatic void model64(input logic [511:0] xv, output logic [511:0] yv,
                                  output logic ov);
    logic signed [65:0] x[8];
    logic signed [65:0] y[8];
    logic signed [65:0] hi;
    for (int k = 0; k < 8; k++) x[k] = 66'($signed(xv[k*64 +: 64]));
    y[0] = x[0] + x[1];
    y[4] = x[0] - x[1];
    y[2] = x[3] + x[2];
    y[6] = x[3] - x[2];
    y[5] = (x[7] - x[5]) + x[4];
    y[3] = (x[7] - x[5]) - x[4];
    y[1] = (x[7] + x[5]) + x[6];
    y[7] = (x[7] + x[5]) - x[6];
    hi = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    ov = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (y[k] > hi || y[k] < -hi - 1) ov = 1'b1;
      yv[k*64 +: 64] = y[k][63:0];
    end
  endfunction

  typedef struct {
    logic [63:0] x;
    logic [63:0] y_wrap;
    logic [63:0] y_sat;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [511:0] exp512, xa;
    logic [255:0] exp_w, exp_s, exp_y;
    logic [255:0] beats[100];
    logic [3:0]   ov_w, ov_s, ov_y;
    logic         ov64;
    logic [511:0] bp_x[5];
    logic [511:0] bp_y[5];
    logic [511:0] held_data;
    logic         held, in_x, out_x;
    longint       y_basic[8];
    int           sent, got, ch;

    // x lanes packed lane 7 in the top byte.
    vecs[0] = '{x: 64'h0706050403020100, y_wrap: 64'h060106FFFE051201, y_sat: 64'h060106FFFE051201, ovf: 1'b0};
    vecs[1] = '{x: 64'h0000000000006464, y_wrap: 64'h00000000000000C8, y_sat: 64'h000000000000007F, ovf: 1'b1};
    vecs[2] = '{x: 64'h7F00800100000000, y_wrap: 64'hFF000000FE00FF00, y_sat: 64'hFF007F007F00FF00, ovf: 1'b1};
    vecs[3] = '{x: 64'h0000000000000180, y_wrap: 64'h0000007F00000081, y_sat: 64'h0000008000000081, ovf: 1'b1};
    vecs[4] = '{x: 64'h00000000C0C0007F, y_wrap: 64'h0000007F0080007F, y_sat: 64'h0000007F0080007F, ovf: 1'b0};
    vecs[5] = '{x: 64'h8080808080808080, y_wrap: 64'h8000800080008000, y_sat: 64'h800080007F808080, ovf: 1'b1};

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_o_valid", a_out_valid, 0);
    check("reset_o_data", a_data_out, 0);
    check("reset_o_ovf", a_ovf, 0);
    check("reset_i_ready", a_ready, 1);

    // Basic 64-bit vector x = 0..7.
    y_basic = '{1, 18, 5, -2, -1, 6, 1, 6};
    @(negedge clk);
    for (int k = 0; k < 8; k++) a_data_in[k*64 +: 64] = 64'(k);
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_data_in = {16{32'hDEADBEEF}};
    check("basic_lat1_valid", a_out_valid, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) exp512[k*64 +: 64] = 64'(y_basic[k]);
    check("basic_valid", a_out_valid, 1);
    check("basic_data", a_data_out, exp512);
    check("basic_ovf", a_ovf, 0);
    @(posedge clk); #1;
    check("basic_drained", a_out_valid, 0);

    // 64-bit overflow: x0 = x1 = max.
    @(negedge clk);
    a_data_in = '0;
    a_data_in[63:0]   = 64'h7FFF_FFFF_FFFF_FFFF;
    a_data_in[127:64] = 64'h7FFF_FFFF_FFFF_FFFF;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk); #1;
    exp512 = '0;
    exp512[63:0] = 64'hFFFF_FFFF_FFFF_FFFE;
    check("ovf64_data", a_data_out, exp512);
    check("ovf64_flag", a_ovf, 1);

    // Table of 8-bit vectors, each placed in one channel.
    for (int i = 0; i < 6; i++) begin
      ch = i % 4;
      @(negedge clk);
      d8 = '0;
      d8[ch*64 +: 64] = vecs[i].x;
      v8 = 1'b1;
      #1;
      check($sformatf("vec%0d_i_ready", i), w8_ready, 1);
      @(posedge clk); #1;
      v8 = 1'b0;
      d8 = {8{32'hA5A5_5A5A}};
      exp_w = '0; exp_w[ch*64 +: 64] = vecs[i].y_wrap;
      exp_s = '0; exp_s[ch*64 +: 64] = vecs[i].y_sat;
      check($sformatf("vec%0d_p1_valid", i), p1_valid, 1);
      check($sformatf("vec%0d_p1_data", i), p1_data, exp_w);
      check($sformatf("vec%0d_p1_ovf", i), p1_ovf, 4'(vecs[i].ovf) << ch);
      check($sformatf("vec%0d_sat_data", i), s8_data, exp_s);
      check($sformatf("vec%0d_sat_ovf", i), s8_ovf, 4'(vecs[i].ovf) << ch);
      check($sformatf("vec%0d_w8_early", i), w8_valid, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_w8_valid", i), w8_valid, 1);
      check($sformatf("vec%0d_w8_data", i), w8_data, exp_w);
      check($sformatf("vec%0d_w8_ovf", i), w8_ovf, 4'(vecs[i].ovf) << ch);
      check($sformatf("vec%0d_p1_gone", i), p1_valid, 0);
    end

    // Back-pressure: five beats, o_ready low in cycles 2..4.
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 8; k++) bp_x[b][k*64 +: 64] = 64'(b * 10 + k);
      model64(bp_x[b], bp_y[b], ov64);
    end
    sent = 0;
    got  = 0;
    held = 1'b0;
    held_data = '0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge clk);
      a_out_ready = !(cyc >= 2 && cyc <= 4);
      if (sent < 5) begin
        a_valid = 1'b1;
        a_data_in = bp_x[sent];
      end else begin
        a_valid = 1'b0;
        a_data_in = {16{32'h1234_5678}};
      end
      #1;
      if (held) begin
        check($sformatf("stall_valid_c%0d", cyc), a_out_valid, 1);
        check($sformatf("stall_data_c%0d", cyc), a_data_out, held_data);
      end
      if (cyc >= 2 && cyc <= 4) check($sformatf("stall_i_ready_c%0d", cyc), a_ready, 0);
      in_x  = a_valid && a_ready;
      out_x = a_out_valid && a_out_ready;
      if (out_x) begin
        check($sformatf("bp_beat%0d_data", got), a_data_out, bp_y[got]);
        check($sformatf("bp_beat%0d_ovf", got), a_ovf, 0);
        got++;
      end
      held = a_out_valid && !a_out_ready;
      held_data = a_data_out;
      @(posedge clk);
      if (in_x) sent++;
    end
    check("bp_beats_out", got, 5);
    @(negedge clk);
    a_valid = 1'b0;
    a_out_ready = 1'b1;

    // Reset with two beats in flight.
    @(negedge clk);
    a_data_in = bp_x[1];
    a_valid = 1'b1;
    @(negedge clk);
    a_data_in = bp_x[2];
    @(negedge clk);
    a_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_o_valid", a_out_valid, 0);
    check("rst_mid_o_data", a_data_out, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rel_i_ready", a_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst_no_stale_%0d", c), a_out_valid, 0);
    end

    // Full throughput, random beats biased toward the range limits.
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      for (int l = 0; l < 32; l++) begin
        case ($urandom_range(0, 3))
          0:       d8[l*8 +: 8] = 8'h7F;
          1:       d8[l*8 +: 8] = 8'h80;
          default: d8[l*8 +: 8] = 8'($urandom);
        endcase
      end
      v8 = 1'b1;
      beats[n] = d8;
      @(posedge clk); #1;
      model8(beats[n], 1'b0, exp_w, ov_w);
      model8(beats[n], 1'b1, exp_s, ov_s);
      check($sformatf("rnd%0d_p1_valid", n), p1_valid, 1);
      check($sformatf("rnd%0d_p1_data", n), {p1_ovf, p1_data}, {ov_w, exp_w});
      check($sformatf("rnd%0d_sat_data", n), {s8_ovf, s8_data}, {ov_s, exp_s});
      if (n == 0) begin
        check("rnd0_w8_fill", w8_valid, 0);
      end else begin
        model8(beats[n-1], 1'b0, exp_y, ov_y);
        check($sformatf("rnd%0d_w8_valid", n), w8_valid, 1);
        check($sformatf("rnd%0d_w8_data", n), {w8_ovf, w8_data}, {ov_y, exp_y});
      end
    end
    @(negedge clk);
    v8 = 1'b0;
    @(posedge clk); #1;
    model8(beats[99], 1'b0, exp_y, ov_y);
    check("rnd_last_w8_valid", w8_valid, 1);
    check("rnd_last_w8_data", {w8_ovf, w8_data}, {ov_y, exp_y});
    check("rnd_last_p1_empty", p1_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
